// File: rtl/btn_pkg.sv
// btn_pkg: debounce state encoding and raw-pin polarity helper shared by the button front end.
package btn_pkg;
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, DOWN, RELEASE_WAIT} btn_state_e;
  localparam bit BTN_PRESSED_RAW_LOW = 1'b1;
  function automatic logic pressed_level(input logic raw, input bit active_low);
    return raw ^ active_low;
  endfunction
endpackage

// File: rtl/debounce_fsm.sv
// debounce_fsm: two-flop synchroniser plus counting debounce FSM producing a clean pressed level and press/release pulses.
module debounce_fsm
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit BTN_ACTIVE_LOW  = BTN_PRESSED_RAW_LOW
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw_i,
  output logic       pressed_o,
  output logic       press_o,
  output logic       release_o,
  output btn_state_e state_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [1:0] sync_q;
  logic p;
  btn_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // Polarity is folded in ahead of the flops so a cleared synchroniser reads "not pressed".
  assign p = sync_q[1];
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_o   = 1'b0;
    release_o = 1'b0;
    unique case (state_q)
      IDLE: if (p) begin
        state_d = PRESS_WAIT;
        cnt_d   = CW'(1);
      end
      PRESS_WAIT: if (!p) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else if (cnt_q == LAST) begin
        state_d = DOWN;
        cnt_d   = '0;
        press_o = 1'b1;
      end else cnt_d = cnt_q + 1'b1;
      DOWN: if (!p) begin
        state_d = RELEASE_WAIT;
        cnt_d   = CW'(1);
      end
      RELEASE_WAIT: if (p) begin
        state_d = DOWN;
        cnt_d   = '0;
      end else if (cnt_q == LAST) begin
        state_d   = IDLE;
        cnt_d     = '0;
        release_o = 1'b1;
      end else cnt_d = cnt_q + 1'b1;
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], pressed_level(btn_raw_i, BTN_ACTIVE_LOW)};
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  assign pressed_o = (state_q == DOWN) || (state_q == RELEASE_WAIT);
  assign state_o   = state_q;
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: debounced run toggle and clear control for the counter chain.
// Optional LONG_PRESS_CLR_EN: holding run for LONG_CYCLES acts as a clear pulse without lowering clr_n.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit BTN_ACTIVE_LOW  = BTN_PRESSED_RAW_LOW,
  parameter int LONG_CYCLES     = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_run_raw,
  input  logic btn_clr_raw,
  output logic run_en,
  output logic clr_n,
  output logic clr_req
);
  logic run_pressed, run_press, run_release;
  logic clr_pressed, clr_press, clr_release;
  btn_state_e run_state, clr_state;
  logic long_fire;
  logic run_en_q, run_en_d, clr_n_q, clr_n_d, clr_req_q, clr_req_d;
  debounce_fsm #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW)) u_run (
    .clk(clk), .rst(rst), .btn_raw_i(btn_run_raw), .pressed_o(run_pressed),
    .press_o(run_press), .release_o(run_release), .state_o(run_state)
  );
  debounce_fsm #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW)) u_clr (
    .clk(clk), .rst(rst), .btn_raw_i(btn_clr_raw), .pressed_o(clr_pressed),
    .press_o(clr_press), .release_o(clr_release), .state_o(clr_state)
  );
`ifdef LONG_PRESS_CLR_EN
  localparam int LW = $clog2(LONG_CYCLES + 1);
  logic [LW-1:0] long_q, long_d;
  // Saturating at LONG_CYCLES makes the long press fire only once per hold.
  assign long_fire = (run_state == DOWN) && (long_q == LW'(LONG_CYCLES - 1));
  assign long_d = (run_state != DOWN) ? '0 : (long_q == LW'(LONG_CYCLES)) ? long_q : long_q + 1'b1;
  always_ff @(posedge clk) begin
    if (rst) long_q <= '0;
    else long_q <= long_d;
  end
`else
  assign long_fire = 1'b0;
`endif
  logic unused_ok;
  assign unused_ok = ^{run_pressed, run_release, run_state, clr_pressed, clr_state, LONG_CYCLES};
  // Clear (pending, accepted or long-press) always beats a run toggle.
  always_comb begin
    clr_req_d = clr_press || long_fire;
    run_en_d  = (clr_req_d || !clr_n_q) ? 1'b0 : run_press ? !run_en_q : run_en_q;
    clr_n_d   = clr_press ? 1'b0 : clr_release ? 1'b1 : clr_n_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      run_en_q  <= 1'b0;
      clr_n_q   <= 1'b1;
      clr_req_q <= 1'b0;
    end else begin
      run_en_q  <= run_en_d;
      clr_n_q   <= clr_n_d;
      clr_req_q <= clr_req_d;
    end
  end
  assign run_en  = run_en_q;
  assign clr_n   = clr_n_q;
  assign clr_req = clr_req_q;
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: streak-count reference model checked every cycle, plus directed edge-exact checks.
module tb_button_conditioner;
  localparam int D = 4;
  localparam int L = 20;
  logic clk = 1'b0, rst = 1'b1, btn_run_raw = 1'b1, btn_clr_raw = 1'b1;
  logic run_en, clr_n, clr_req;
  int n_cmp = 0, n_bad = 0, req_seen = 0;
  bit model_ok = 1'b0;
  bit m_run, m_clrn, m_req;
  button_conditioner #(.DEBOUNCE_CYCLES(D), .BTN_ACTIVE_LOW(1'b1), .LONG_CYCLES(L)) dut (
    .clk(clk), .rst(rst), .btn_run_raw(btn_run_raw), .btn_clr_raw(btn_clr_raw),
    .run_en(run_en), .clr_n(clr_n), .clr_req(clr_req)
  );
  always #5 clk = ~clk;
  // Model: a button's clean level flips once its synced sample (two edges old) has disagreed for D edges in a row.
  initial begin
    bit [1:0] hr, hc;
    bit p[2], lvl[2], press[2], rel[2];
    int streak[2];
    int lcount;
    bit fire;
    forever begin
      @(posedge clk);
      if (rst) begin
        hr = '0; hc = '0; lvl = '{0, 0}; streak = '{0, 0}; lcount = 0;
        m_run = 0; m_clrn = 1; m_req = 0;
      end else begin
        p[0] = hr[1]; p[1] = hc[1];
        hr = {hr[0], ~btn_run_raw}; hc = {hc[0], ~btn_clr_raw};
        fire = 0;
`ifdef LONG_PRESS_CLR_EN
        if (lvl[0] && streak[0] == 0) begin lcount++; fire = (lcount == L); end else lcount = 0;
`endif
        for (int b = 0; b < 2; b++) begin
          press[b] = 0; rel[b] = 0;
          if (p[b] != lvl[b]) begin
            streak[b]++;
            if (streak[b] == D) begin
              lvl[b] = ~lvl[b]; streak[b] = 0;
              if (lvl[b]) press[b] = 1; else rel[b] = 1;
            end
          end else streak[b] = 0;
        end
        m_req = press[1] || fire;
        if (m_req || !m_clrn) m_run = 0; else if (press[0]) m_run = ~m_run;
        if (press[1]) m_clrn = 0; else if (rel[1]) m_clrn = 1;
      end
      model_ok = 1'b1;
    end
  end
  initial forever begin
    @(negedge clk);
    if (clr_req === 1'b1) req_seen++;
    if (model_ok) begin
      n_cmp++;
      if ({run_en, clr_n, clr_req} !== {m_run, m_clrn, m_req}) begin
        n_bad++;
        $display("FAIL model_cmp @%0t: got run_en=%b clr_n=%b clr_req=%b, expected %b %b %b",
                 $time, run_en, clr_n, clr_req, m_run, m_clrn, m_req);
      end
    end
  end
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask
  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  initial begin
    int base;
    edges(3);
    check("reset run_en", int'(run_en), 0);
    check("reset clr_n", int'(clr_n), 1);
    check("reset clr_req", int'(clr_req), 0);
    rst = 0;
    edges(2);
    btn_run_raw = 0;
    edges(5); check("t1 edge5 run_en", int'(run_en), 0);
    edges(1); check("t1 edge6 run_en", int'(run_en), 1);
    btn_run_raw = 1; edges(8);
    check("t1 release keeps run_en", int'(run_en), 1);
    btn_run_raw = 0;
    edges(5); check("t1 second edge5 run_en", int'(run_en), 1);
    edges(1); check("t1 second edge6 run_en", int'(run_en), 0);
    btn_run_raw = 1; edges(8);
    base = req_seen;
    btn_run_raw = 0; edges(3); btn_run_raw = 1; edges(1);
    btn_run_raw = 0; edges(3); btn_run_raw = 1; edges(10);
    check("t2 bounce run_en", int'(run_en), 0);
    check("t2 bounce clr_req pulses", req_seen - base, 0);
    btn_run_raw = 0; edges(6);
    check("t3 run_en before clear", int'(run_en), 1);
    btn_run_raw = 1; edges(8);
    base = req_seen;
    btn_clr_raw = 0;
    edges(5);
    check("t3 edge5 clr_req", int'(clr_req), 0);
    check("t3 edge5 clr_n", int'(clr_n), 1);
    edges(1);
    check("t3 edge6 clr_req", int'(clr_req), 1);
    check("t3 edge6 clr_n", int'(clr_n), 0);
    check("t3 edge6 run_en", int'(run_en), 0);
    edges(1); check("t3 edge7 clr_req", int'(clr_req), 0);
    btn_run_raw = 0; edges(6);
    check("t3 run ignored while clear held", int'(run_en), 0);
    btn_run_raw = 1; edges(8);
    check("t3 single clr_req pulse", req_seen - base, 1);
    btn_clr_raw = 1;
    edges(5); check("t3 release edge5 clr_n", int'(clr_n), 0);
    edges(1); check("t3 release edge6 clr_n", int'(clr_n), 1);
    edges(4);
    btn_run_raw = 0; btn_clr_raw = 0;
    edges(5); check("t4 edge5 clr_req", int'(clr_req), 0);
    edges(1);
    check("t4 edge6 clr_req", int'(clr_req), 1);
    check("t4 edge6 run_en", int'(run_en), 0);
    check("t4 edge6 clr_n", int'(clr_n), 0);
    btn_run_raw = 1; btn_clr_raw = 1; edges(8);
    check("t4 clr_n after release", int'(clr_n), 1);
    btn_run_raw = 0; edges(2);
    rst = 1; edges(1);
    check("t5 run_en in reset", int'(run_en), 0);
    rst = 0;
    edges(5); check("t5 edge5 after rst run_en", int'(run_en), 0);
    edges(1); check("t5 edge6 after rst run_en", int'(run_en), 1);
    btn_run_raw = 1; edges(8);
    rst = 1; edges(1); rst = 0;
    base = req_seen;
    btn_run_raw = 0;
    edges(6); check("t6 edge6 run_en", int'(run_en), 1);
    edges(19);
    check("t6 edge25 run_en", int'(run_en), 1);
    check("t6 edge25 clr_req", int'(clr_req), 0);
    edges(1);
`ifdef LONG_PRESS_CLR_EN
    check("t6 edge26 clr_req", int'(clr_req), 1);
    check("t6 edge26 run_en", int'(run_en), 0);
    check("t6 edge26 clr_n", int'(clr_n), 1);
    edges(30);
    check("t6 one pulse per hold", req_seen - base, 1);
`else
    check("t6 edge26 clr_req", int'(clr_req), 0);
    check("t6 edge26 run_en", int'(run_en), 1);
    edges(30);
    check("t6 no long press pulse", req_seen - base, 0);
`endif
    btn_run_raw = 1; edges(8);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
